// File: rtl/fp_pkg.sv
// Shared constants and width helpers for the floating-point unpack front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

   // Bit positions inside the one-hot class vector {nan, inf, zero, dnorm, norm}
   localparam int CLS_NORM  = 0;
   localparam int CLS_DNORM = 1;
   localparam int CLS_ZERO  = 2;
   localparam int CLS_INF   = 3;
   localparam int CLS_NAN   = 4;
   localparam int CLS_W     = 5;

   // IEEE exponent bias for an exponent field of n_exp bits
   function automatic int fp_bias(input int n_exp);
      return (1 << (n_exp - 1)) - 1;
   endfunction

   // Width needed to hold a leading-zero count of 0..n_man
   function automatic int fp_lz_width(input int n_man);
      return $clog2(n_man + 1);
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter, log-depth binary search; all-zero input returns N.
// Latency: combinational.
// Backpressure: none (pure function of in_dat).
module fp_lzc #(
   parameter int N    = 52,
   parameter int LZ_W = 6
) (
   input  logic [N-1:0]    in_dat,
   output logic [LZ_W-1:0] lz
);

   // Search window padded to a power of two with trailing ones, so an
   // all-zero operand naturally finds its first one at position N.
   localparam int P = 1 << LZ_W;

   logic [P-1:0] stg [0:LZ_W-1];

   assign stg[0] = {in_dat, {(P - N){1'b1}}};

   // Each level tests the upper half of what remains and shifts it out if empty
   for (genvar i = 0; i < LZ_W; i++) begin : g_lvl
      localparam int K = LZ_W - 1 - i;
      localparam int W = 1 << K;
      assign lz[K] = ~|stg[i][P-1 -: W];
      if (i < LZ_W - 1) begin : g_next
         assign stg[i+1] = lz[K] ? (stg[i] << W) : stg[i];
      end
   end

endmodule

// File: rtl/fp_unpack_pipe.sv
// IEEE-754 classifier/unpacker: sign, unbiased exponent, normalised mantissa, one-hot class.
// Latency: 2 cycles, 1 operand/cycle; optional out_snan port under FP_UNPACK_SNAN_EN.
// Backpressure: valid/ready; stalled outputs hold bit-for-bit, in_ready = s1 can advance.
module fp_unpack_pipe
   import fp_pkg::*;
#(
   parameter int N_EXP = 11,
   parameter int N_MAN = 52,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_EXP+N_MAN:0]   in_f,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sign,
   output logic [N_EXP+1:0]       out_exp,
   output logic [N_MAN:0]         out_man,
   output logic [CLS_W-1:0]       out_class,
   output logic [TAG_W-1:0]       out_tag
`ifdef FP_UNPACK_SNAN_EN
   ,
   output logic                   out_snan
`endif
);

   localparam int BIAS = fp_bias(N_EXP);
   localparam int EMIN = 1 - BIAS;
   localparam int EMAX = BIAS;
   localparam int LZ_W = fp_lz_width(N_MAN);
   localparam int EW   = N_EXP + 2;

   localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
   localparam logic signed [EW-1:0] EMIN_E  = EW'(EMIN);
   localparam logic signed [EW-1:0] EINF_E  = EW'(EMAX + 1);
   localparam logic signed [EW-1:0] ONE_E   = EW'(1);

   // Input field split and classification
   logic                sign_in;
   logic [N_EXP-1:0]    exp_in;
   logic [N_MAN-1:0]    frac_in;
   logic [LZ_W-1:0]     lz_in;
   logic [CLS_W-1:0]    cls_in;

   assign sign_in = in_f[N_EXP+N_MAN];
   assign exp_in  = in_f[N_MAN +: N_EXP];
   assign frac_in = in_f[N_MAN-1:0];

   fp_lzc #(.N(N_MAN), .LZ_W(LZ_W)) u_lzc (
      .in_dat (frac_in),
      .lz     (lz_in)
   );

   // Stage registers
   logic                s1_valid_d, s1_valid_q;
   logic                s1_sign_d,  s1_sign_q;
   logic [N_EXP-1:0]    s1_exp_d,   s1_exp_q;
   logic [N_MAN-1:0]    s1_frac_d,  s1_frac_q;
   logic [CLS_W-1:0]    s1_cls_d,   s1_cls_q;
   logic [LZ_W-1:0]     s1_lz_d,    s1_lz_q;
   logic [TAG_W-1:0]    s1_tag_d,   s1_tag_q;

   logic                s2_valid_d, s2_valid_q;
   logic                s2_sign_d,  s2_sign_q;
   logic [EW-1:0]       s2_exp_d,   s2_exp_q;
   logic [N_MAN:0]      s2_man_d,   s2_man_q;
   logic [CLS_W-1:0]    s2_cls_d,   s2_cls_q;
   logic [TAG_W-1:0]    s2_tag_d,   s2_tag_q;
`ifdef FP_UNPACK_SNAN_EN
   logic                s2_snan_d,  s2_snan_q;
`endif

   logic s1_adv, s2_adv;
   logic signed [EW-1:0] lz_ext;
   logic [N_MAN:0]       frac_ext;

   // Pipeline advance: a stage may load when empty or when its successor moves
   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   // One-hot class from the all-zeros / all-ones exponent and zero fraction tests
   always_comb begin
      cls_in = '0;
      cls_in[CLS_ZERO]  = ~|exp_in & ~|frac_in;
      cls_in[CLS_DNORM] = ~|exp_in &  |frac_in;
      cls_in[CLS_INF]   =  &exp_in & ~|frac_in;
      cls_in[CLS_NAN]   =  &exp_in &  |frac_in;
      cls_in[CLS_NORM]  =  |exp_in & ~&exp_in;
   end

   // S1: capture the raw fields, class and leading-zero count on input transfer
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_frac_d  = s1_frac_q;
      s1_cls_d   = s1_cls_q;
      s1_lz_d    = s1_lz_q;
      s1_tag_d   = s1_tag_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
      end
      if (s1_adv & in_valid) begin
         s1_sign_d = sign_in;
         s1_exp_d  = exp_in;
         s1_frac_d = frac_in;
         s1_cls_d  = cls_in;
         s1_lz_d   = lz_in;
         s1_tag_d  = in_tag;
      end
   end

   assign lz_ext   = EW'(s1_lz_q);
   assign frac_ext = {1'b0, s1_frac_q};

   // S2: unbias the exponent and normalise denormals, holding while stalled
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_exp_d   = s2_exp_q;
      s2_man_d   = s2_man_q;
      s2_cls_d   = s2_cls_q;
      s2_tag_d   = s2_tag_q;
`ifdef FP_UNPACK_SNAN_EN
      s2_snan_d  = s2_snan_q;
`endif
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s2_adv & s1_valid_q) begin
         s2_sign_d = s1_sign_q;
         s2_cls_d  = s1_cls_q;
         s2_tag_d  = s1_tag_q;
`ifdef FP_UNPACK_SNAN_EN
         s2_snan_d = s1_cls_q[CLS_NAN] & ~s1_frac_q[N_MAN-1];
`endif
         if (s1_cls_q[CLS_NORM]) begin
            s2_exp_d = $signed({2'b00, s1_exp_q}) - BIAS_E;
            s2_man_d = {1'b1, s1_frac_q};
         end else if (s1_cls_q[CLS_DNORM]) begin
            // Shift the first one of the fraction up into the hidden-bit slot
            s2_exp_d = EMIN_E - lz_ext - ONE_E;
            s2_man_d = (frac_ext << s1_lz_q) << 1;
         end else if (s1_cls_q[CLS_INF] | s1_cls_q[CLS_NAN]) begin
            s2_exp_d = EINF_E;
            s2_man_d = frac_ext;
         end else begin
            s2_exp_d = '0;
            s2_man_d = '0;
         end
      end
   end

   // State registers; reset clears every stage so in-flight operands are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_frac_q  <= '0;
         s1_cls_q   <= '0;
         s1_lz_q    <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_exp_q   <= '0;
         s2_man_q   <= '0;
         s2_cls_q   <= '0;
         s2_tag_q   <= '0;
`ifdef FP_UNPACK_SNAN_EN
         s2_snan_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_exp_q   <= s1_exp_d;
         s1_frac_q  <= s1_frac_d;
         s1_cls_q   <= s1_cls_d;
         s1_lz_q    <= s1_lz_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_sign_q  <= s2_sign_d;
         s2_exp_q   <= s2_exp_d;
         s2_man_q   <= s2_man_d;
         s2_cls_q   <= s2_cls_d;
         s2_tag_q   <= s2_tag_d;
`ifdef FP_UNPACK_SNAN_EN
         s2_snan_q  <= s2_snan_d;
`endif
      end
   end

   assign out_valid = s2_valid_q;
   assign out_sign  = s2_sign_q;
   assign out_exp   = s2_exp_q;
   assign out_man   = s2_man_q;
   assign out_class = s2_cls_q;
   assign out_tag   = s2_tag_q;
`ifdef FP_UNPACK_SNAN_EN
   assign out_snan  = s2_snan_q;
`endif

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: single-precision table, streaming stall, reset, one double.
// Latency: checks the 2-cycle input-to-output latency.
// Backpressure: exercises out_ready stalls and in_ready gating.
module tb_fp_unpack_pipe;

   typedef struct {
      logic [31:0] f;
      int          e_exp;
      logic [23:0] e_man;
      logic [4:0]  e_cls;
      logic        e_sign;
      logic        e_snan;
   } vec_t;

   localparam int NV = 13;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        sp_in_valid = 1'b0, sp_out_ready = 1'b1;
   logic        sp_in_ready, sp_out_valid, sp_out_sign;
   logic [31:0] sp_in_f = '0;
   logic [3:0]  sp_in_tag = '0, sp_out_tag;
   logic [9:0]  sp_out_exp;
   logic [23:0] sp_out_man;
   logic [4:0]  sp_out_class;

   logic        dp_in_valid = 1'b0, dp_out_ready = 1'b1;
   logic        dp_in_ready, dp_out_valid, dp_out_sign;
   logic [63:0] dp_in_f = '0;
   logic [3:0]  dp_in_tag = '0, dp_out_tag;
   logic [12:0] dp_out_exp;
   logic [52:0] dp_out_man;
   logic [4:0]  dp_out_class;
`ifdef FP_UNPACK_SNAN_EN
   logic        sp_out_snan, dp_out_snan;
`endif

   int   checks = 0;
   int   errors = 0;
   vec_t tbl [NV];

   always #5 clk = ~clk;

   fp_unpack_pipe #(.N_EXP(8), .N_MAN(23), .TAG_W(4)) u_sp (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sp_in_valid), .in_ready(sp_in_ready), .in_f(sp_in_f), .in_tag(sp_in_tag),
      .out_valid(sp_out_valid), .out_ready(sp_out_ready), .out_sign(sp_out_sign),
      .out_exp(sp_out_exp), .out_man(sp_out_man), .out_class(sp_out_class), .out_tag(sp_out_tag)
`ifdef FP_UNPACK_SNAN_EN
      , .out_snan(sp_out_snan)
`endif
   );

   fp_unpack_pipe u_dp (
      .clk(clk), .rst_n(rst_n),
      .in_valid(dp_in_valid), .in_ready(dp_in_ready), .in_f(dp_in_f), .in_tag(dp_in_tag),
      .out_valid(dp_out_valid), .out_ready(dp_out_ready), .out_sign(dp_out_sign),
      .out_exp(dp_out_exp), .out_man(dp_out_man), .out_class(dp_out_class), .out_tag(dp_out_tag)
`ifdef FP_UNPACK_SNAN_EN
      , .out_snan(dp_out_snan)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic chk_sp_fields(input string nm, input int i);
      int e;
      e = $signed(sp_out_exp);
      chk_i({nm, "_exp"}, e, tbl[i].e_exp);
      chk({nm, "_man"}, 64'(sp_out_man), 64'(tbl[i].e_man));
      chk({nm, "_cls"}, 64'(sp_out_class), 64'(tbl[i].e_cls));
      chk({nm, "_sign"}, 64'(sp_out_sign), 64'(tbl[i].e_sign));
   endtask

   // One operand with out_ready high; checks both latency points and all fields
   task automatic apply_vec(input int i);
      @(negedge clk);
      sp_out_ready = 1'b1;
      sp_in_valid  = 1'b1;
      sp_in_f      = tbl[i].f;
      sp_in_tag    = 4'(i);
      @(negedge clk);
      sp_in_valid  = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), 64'(sp_out_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_lat2_valid", i), 64'(sp_out_valid), 64'd1);
      chk_sp_fields($sformatf("v%0d", i), i);
      chk($sformatf("v%0d_tag", i), 64'(sp_out_tag), 64'(i[3:0]));
`ifdef FP_UNPACK_SNAN_EN
      chk($sformatf("v%0d_snan", i), 64'(sp_out_snan), 64'(tbl[i].e_snan));
`endif
   endtask

   initial begin
      int occ, sent, recv, e;
      bit held;
      logic [9:0]  h_exp;
      logic [23:0] h_man;
      logic [4:0]  h_cls;
      logic [3:0]  h_tag;
      logic        h_sign;
      logic        in_x, out_x;

      //         f              exp    man          class     sign  snan
      tbl[0]  = '{32'h3F800000,    0, 24'h800000, 5'b00001, 1'b0, 1'b0};
      tbl[1]  = '{32'h00000001, -149, 24'h800000, 5'b00010, 1'b0, 1'b0};
      tbl[2]  = '{32'h80400000, -127, 24'h800000, 5'b00010, 1'b1, 1'b0};
      tbl[3]  = '{32'h80000000,    0, 24'h000000, 5'b00100, 1'b1, 1'b0};
      tbl[4]  = '{32'h7F800000,  128, 24'h000000, 5'b01000, 1'b0, 1'b0};
      tbl[5]  = '{32'h7FC00000,  128, 24'h400000, 5'b10000, 1'b0, 1'b0};
      tbl[6]  = '{32'h7F800001,  128, 24'h000001, 5'b10000, 1'b0, 1'b1};
      tbl[7]  = '{32'hC0490FDB,    1, 24'hC90FDB, 5'b00001, 1'b1, 1'b0};
      tbl[8]  = '{32'h7F7FFFFF,  127, 24'hFFFFFF, 5'b00001, 1'b0, 1'b0};
      tbl[9]  = '{32'h00800000, -126, 24'h800000, 5'b00001, 1'b0, 1'b0};
      tbl[10] = '{32'h007FFFFF, -127, 24'hFFFFFE, 5'b00010, 1'b0, 1'b0};
      tbl[11] = '{32'hFFC00001,  128, 24'h400001, 5'b10000, 1'b1, 1'b0};
      tbl[12] = '{32'h00000000,    0, 24'h000000, 5'b00100, 1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst_out_valid", 64'(sp_out_valid), 64'd0);
      chk("rst_in_ready", 64'(sp_in_ready), 64'd1);
      chk("rst_class", 64'(sp_out_class), 64'd0);
      chk("rst_man", 64'(sp_out_man), 64'd0);
      chk("rst_dp_valid", 64'(dp_out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) apply_vec(i);

      // Double precision: smallest denormal
      @(negedge clk);
      dp_in_valid = 1'b1;
      dp_in_f     = 64'h0000000000000001;
      dp_in_tag   = 4'hA;
      @(negedge clk);
      dp_in_valid = 1'b0;
      @(negedge clk);
      e = $signed(dp_out_exp);
      chk("dp_valid", 64'(dp_out_valid), 64'd1);
      chk_i("dp_exp", e, -1074);
      chk("dp_man", 64'(dp_out_man), 64'h0010000000000000);
      chk("dp_cls", 64'(dp_out_class), 64'b00010);
      chk("dp_tag", 64'(dp_out_tag), 64'hA);

      // Stream 8 operands while out_ready follows 1,0,0,1,0,0,...
      occ = 0; sent = 0; recv = 0; held = 0;
      h_exp = '0; h_man = '0; h_cls = '0; h_tag = '0; h_sign = 1'b0;
      for (int c = 0; c < 200 && recv < 8; c++) begin
         @(negedge clk);
         sp_out_ready = (c % 3 == 0);
         sp_in_valid  = (sent < 8);
         if (sent < 8) begin
            sp_in_f   = tbl[sent].f;
            sp_in_tag = 4'(sent);
         end
         #1;
         chk($sformatf("st_in_ready_c%0d", c), 64'(sp_in_ready),
             64'(!(occ == 2 && !sp_out_ready)));
         if (held) begin
            chk($sformatf("st_hold_valid_c%0d", c), 64'(sp_out_valid), 64'd1);
            chk($sformatf("st_hold_exp_c%0d", c), 64'(sp_out_exp), 64'(h_exp));
            chk($sformatf("st_hold_man_c%0d", c), 64'(sp_out_man), 64'(h_man));
            chk($sformatf("st_hold_cls_c%0d", c), 64'(sp_out_class), 64'(h_cls));
            chk($sformatf("st_hold_tag_c%0d", c), 64'(sp_out_tag), 64'(h_tag));
            chk($sformatf("st_hold_sign_c%0d", c), 64'(sp_out_sign), 64'(h_sign));
         end
         held = 1'b0;
         in_x  = sp_in_valid & sp_in_ready;
         out_x = sp_out_valid & sp_out_ready;
         if (sp_out_valid && sp_out_ready) begin
            chk($sformatf("st_tag_r%0d", recv), 64'(sp_out_tag), 64'(recv));
            if (recv < 8) chk_sp_fields($sformatf("st_r%0d", recv), recv);
            recv++;
         end else if (sp_out_valid) begin
            held   = 1'b1;
            h_exp  = sp_out_exp;
            h_man  = sp_out_man;
            h_cls  = sp_out_class;
            h_tag  = sp_out_tag;
            h_sign = sp_out_sign;
         end
         if (in_x) begin
            sent++;
            occ++;
         end
         if (out_x) occ--;
      end
      chk_i("st_recv_count", recv, 8);
      @(negedge clk);
      sp_in_valid  = 1'b0;
      sp_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("st_drained", 64'(sp_out_valid), 64'd0);

      // Reset with two operands in flight
      sp_out_ready = 1'b0;
      sp_in_valid  = 1'b1;
      sp_in_f      = tbl[7].f;
      sp_in_tag    = 4'h9;
      @(negedge clk);
      sp_in_f      = tbl[8].f;
      sp_in_tag    = 4'hA;
      @(negedge clk);
      sp_in_valid  = 1'b0;
      #1;
      chk("rm_full_valid", 64'(sp_out_valid), 64'd1);
      chk("rm_full_in_ready", 64'(sp_in_ready), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rm_valid", 64'(sp_out_valid), 64'd0);
      chk("rm_exp", 64'(sp_out_exp), 64'd0);
      chk("rm_man", 64'(sp_out_man), 64'd0);
      chk("rm_cls", 64'(sp_out_class), 64'd0);
      chk("rm_tag", 64'(sp_out_tag), 64'd0);
      chk("rm_sign", 64'(sp_out_sign), 64'd0);
`ifdef FP_UNPACK_SNAN_EN
      chk("rm_snan", 64'(sp_out_snan), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rm_in_ready", 64'(sp_in_ready), 64'd1);
      apply_vec(0);
      @(negedge clk);
      chk("rm_no_ghost", 64'(sp_out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
